elastic_pipe: RTL and testbench
===============================

# elastic_pipe

Parametrised, stallable pipeline register chain: a successor to the single enable/reset flip-flop. It carries WIDTH-bit data through DEPTH register stages with per-stage valid bits, a ready/valid handshake on both ends, bubble collapsing, a synchronous flush and an occupancy count. It sits between datapath blocks wherever registered, back-pressurable retiming is needed.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, number of register stages (≥1)
- RST_VAL, '0 (WIDTH bits), value loaded into every data stage on reset/flush
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- flush  input  1  synchronous clear of all stages
- in_valid  input  1  upstream item present
- in_ready  output  1  block accepts item this cycle
- in_data  input  WIDTH  upstream data
- out_valid  output  1  last stage holds an item
- out_ready  input  1  downstream accepts item
- out_data  output  WIDTH  last-stage data
- count  output  CW = $clog2(DEPTH+1)  number of valid stages

## Operation
- Stages 0..DEPTH-1; stage 0 fed by input, stage DEPTH-1 drives out_valid/out_data.
- Per-stage ready: rdy[DEPTH] = out_ready; rdy[k] = ~v[k] | rdy[k+1].
- in_ready = rdy[0] & ~flush & ~rst.
- On each edge with rdy[k]: v[k] <= upstream valid (in_valid for k=0, v[k-1] otherwise); d[k] <= upstream data only if upstream valid, else d[k] holds.
- Stage with rdy[k]=0 holds v and d.
- Bubble collapse: an empty stage always accepts, so a stall at the output compacts items toward the output; holes never persist behind a stalled stage.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- count <= count + in_xfer − out_xfer; always equals popcount(v).
- flush (priority over all transfers): all v <= 0, all d <= RST_VAL, count <= 0; item presented at out during the flush cycle is not considered transferred even if out_ready=1 (out_valid still shown; downstream must ignore — documented as a hazard: flush discards everything).
- Reset: all v = 0, all d = RST_VAL, count = 0, out_valid = 0, out_data = RST_VAL, in_ready = 0 while rst high, 1 on first cycle after release.

## Timing
- Latency: item accepted at edge N appears on out_data/out_valid after edge N+DEPTH−1, i.e. visible in cycle N+DEPTH, when no stall.
- Throughput: one item/cycle with out_ready held high.
- in_ready is combinational from out_ready through DEPTH ready terms (documented timing path).
- Full (count = DEPTH) with out_ready=0 → in_ready=0. Full with out_ready=1 → in_ready=1; accept and emit same edge, count unchanged.
- Empty → out_valid=0; out_data holds last value (not required to be RST_VAL).
- rst asserted mid-stream: outputs clear immediately (asynchronous), not at next edge.
- DEPTH=1: single stage, in_ready = ~v | out_ready.

## Structure
- Package elastic_pipe_pkg: function cnt_width(depth) returning $clog2(depth+1); shared handshake struct typedef (valid + data) parametrised via localparam in users.
- One sub-module, pipe_stage: one valid bit + WIDTH data register with load, flush, async reset; elastic_pipe instantiates DEPTH of them in a generate loop plus the ready chain and counter.

## Test plan
- Reset: assert rst mid-cycle with 3 items in flight → out_valid, count drop to 0 without a clock edge; out_data = RST_VAL.
- Streaming: WIDTH=8, DEPTH=4, out_ready=1, in 0x01..0x10 every cycle → out 0x01 first valid 4 cycles after first accept, then one per cycle in order, count steady at 4.
- Back-pressure: out_ready=0, push 0xA0..0xA5 → exactly 4 accepted, in_ready=0 after 4th, count=4; release out_ready → 0xA0..0xA3 drain in order.
- Bubble collapse: push 0x11, idle 2 cycles, push 0x22 with out_ready=0 → both reach stages 3 and 2, count=2, in_ready=1.
- Full simultaneous: full, out_ready=1, in_valid=1 with 0x55 → pop and push same edge, count stays 4, 0x55 emerges after 4 cycles.
- Flush: 3 items held, flush=1 with in_valid=1 → in_ready=0, next cycle count=0, out_valid=0, no item lost/duplicated afterward.

Source files
------------

// File: rtl/elastic_pipe_pkg.sv
// Shared definitions for the elastic pipeline: default geometry and the
// occupancy-counter width helper.
package elastic_pipe_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Bits needed to hold an occupancy value from 0 up to and including depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// One elastic stage: a valid bit plus a data register. Data only moves when
// the upstream slot actually carries an item, so an empty stage keeps its
// last contents.
module pipe_stage
    import elastic_pipe_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Stage register: reset/flush clear, otherwise capture upstream when allowed to advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= RST_VAL;
        end else if (flush) begin
            valid <= 1'b0;
            data  <= RST_VAL;
        end else if (load) begin
            valid <= in_valid;
            if (in_valid) begin
                data <= in_data;
            end
        end
    end

endmodule

// File: rtl/elastic_pipe.sv
// Stallable register chain with ready/valid on both ends. Each stage accepts
// whenever it is empty or its successor is advancing, which collapses bubbles
// behind a stall. in_ready is combinational from out_ready through the whole
// ready chain; that path grows with DEPTH.
module elastic_pipe
    import elastic_pipe_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter int               DEPTH   = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              CW      = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } hs_t;

    hs_t              up [DEPTH];
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH:0]   rdy;
    logic             in_xfer;
    logic             out_xfer;

    // Ready chain: a stage can take an item if it is empty or its own item moves on.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            rdy[k] = ~v[k] | rdy[k+1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign up[k] = '{valid: in_valid, data: in_data};
        end else begin : g_body
            assign up[k] = '{valid: v[k-1], data: d[k-1]};
        end

        pipe_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .load     (rdy[k]),
            .in_valid (up[k].valid),
            .in_data  (up[k].data),
            .valid    (v[k]),
            .data     (d[k])
        );
    end

    assign in_ready  = rdy[0] & ~flush & ~rst;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    // A flush discards the item on the output, so it never counts as leaving.
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready & ~flush;

    // Occupancy counter tracking accepted minus delivered items.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({in_xfer, out_xfer})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_elastic_pipe.sv
// Testbench for elastic_pipe: directed scenarios plus random traffic, with a
// FIFO scoreboard checked by a monitor on the falling clock edge.
module tb_elastic_pipe;

    localparam int         WIDTH   = 8;
    localparam int         DEPTH   = 4;
    localparam int         CW      = $clog2(DEPTH + 1);
    localparam logic [7:0] RST_VAL = 8'h5A;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] sb [$];

    elastic_pipe #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .RST_VAL (RST_VAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 2) step();
    endtask

    // Reference model: the pipe behaves as a FIFO of accepted items, is full
    // only when DEPTH items are held, and a flush empties it.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            chk("count", 32'(count), 32'(sb.size()));
            chk("in_ready", 32'(in_ready),
                32'(!flush && ((sb.size() < DEPTH) || out_ready)));
            if (sb.size() == 0) chk("out_valid_empty", 32'(out_valid), 32'd0);
            if (flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready && sb.size() != 0) begin
                    logic [WIDTH-1:0] exp;
                    exp = sb.pop_front();
                    chk("out_data", 32'(out_data), 32'(exp));
                end
                if (in_valid && in_ready) sb.push_back(in_data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int acc;

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'(RST_VAL));
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Streaming at full rate
        out_ready = 1'b1;
        first     = -1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i + 1);
            step();
            if (out_valid && first < 0) first = i + 1;
            if (i >= 3) begin
                chk("stream_count", 32'(count), 32'(DEPTH));
                chk("stream_data", 32'(out_data), 32'(i - 2));
            end
        end
        chk("stream_latency", 32'(first), 32'(DEPTH));
        drain();

        // Back-pressure
        out_ready = 1'b0;
        acc       = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hA0 + i);
            #1;
            if (in_ready) acc++;
            step();
        end
        in_valid = 1'b0;
        #1;
        chk("bp_accepted", 32'(acc), 32'd4);
        chk("bp_count", 32'(count), 32'(DEPTH));
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_head", 32'(out_data), 32'hA0);
        drain();

        // Bubble collapse
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        step();
        in_valid = 1'b0;
        step();
        step();
        in_valid = 1'b1;
        in_data  = 8'h22;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("bubble_count", 32'(count), 32'd2);
        chk("bubble_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        #1;
        chk("bubble_first_valid", 32'(out_valid), 32'd1);
        chk("bubble_first_data", 32'(out_data), 32'h11);
        step();
        chk("bubble_second_valid", 32'(out_valid), 32'd1);
        chk("bubble_second_data", 32'(out_data), 32'h22);
        drain();

        // Full with simultaneous push and pop
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h51 + i);
            step();
        end
        in_data   = 8'h55;
        out_ready = 1'b1;
        #1;
        chk("full_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("full_count", 32'(count), 32'(DEPTH));
        repeat (3) step();
        chk("full_tail_valid", 32'(out_valid), 32'd1);
        chk("full_tail_data", 32'(out_data), 32'h55);
        drain();

        // Flush with items held and an item offered
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h61 + i);
            step();
        end
        in_data   = 8'h99;
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_out_data", 32'(out_data), 32'(RST_VAL));
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h71 + i);
            step();
        end
        drain();

        // Asynchronous reset with items in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h81 + i);
            step();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'(RST_VAL));
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("arst_release_in_ready", 32'(in_ready), 32'd1);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 39) == 0);
            step();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
